// File: rtl/vermicom_tx_fifo_if.sv
// Vermicom TX FIFO handshake bundle: producer push side and
// first-word-fall-through pop side toward the UART serialiser.
interface vermicom_tx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/vermicom_tx_fifo.sv
// Vermicom UART TX byte FIFO, first-word fall-through.
// Optional sticky overflow flag: VERMICOM_TX_FIFO_OVERFLOW_EN.
module vermicom_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  vermicom_tx_fifo_if.slave          bus,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       below_threshold,
  input  logic                       clear_overflow,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] L_THR  = LW'(THRESHOLD);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == L_FULL);

  // flush wins over any handshake in the same cycle
  assign w_push = bus.in_valid && !w_full && !flush;
  assign w_pop  = bus.out_ready && !w_empty && !flush;

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

  assign level           = r_level;
  assign empty           = w_empty;
  assign full            = w_full;
  assign below_threshold = (r_level < L_THR);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case (1'b1)
        (w_push && !w_pop): r_level <= r_level + 1'b1;
        (w_pop && !w_push): r_level <= r_level - 1'b1;
        default:            r_level <= r_level;
      endcase
    end
  end

`ifdef VERMICOM_TX_FIFO_OVERFLOW_EN
  logic r_overflow;
  logic w_ovf_set;

  assign w_ovf_set = bus.in_valid && w_full && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_clr;

  assign w_unused_clr = clear_overflow;
  assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_vermicom_tx_fifo.sv
// Self-checking bench for vermicom_tx_fifo against a queue model.
// Directed steps followed by a randomized traffic phase.
module tb_vermicom_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int THRESHOLD = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;
  logic          below_threshold;
  logic          overflow;

  vermicom_tx_fifo_if bus();

  vermicom_tx_fifo #(
    .DEPTH     (DEPTH),
    .THRESHOLD (THRESHOLD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .bus             (bus),
    .level           (level),
    .empty           (empty),
    .full            (full),
    .below_threshold (below_threshold),
    .clear_overflow  (clear_overflow),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] q[$];
  logic [7:0] popped[$];
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = q.size();
    chk("level", 32'(level), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("below_thr", 32'(below_threshold), 32'(sz < THRESHOLD));
    chk("in_ready", 32'(bus.in_ready), 32'(sz != DEPTH));
    chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
    chk("out_data", 32'(bus.out_data), (sz != 0) ? 32'(q[0]) : 32'h0);
`ifdef VERMICOM_TX_FIFO_OVERFLOW_EN
    chk("overflow", 32'(overflow), 32'(m_ovf));
`else
    chk("overflow", 32'(overflow), 32'h0);
`endif
  endtask

  task automatic model_update(input logic iv, input logic [7:0] d,
                              input logic ordy, input logic fl,
                              input logic clr);
    int sz;
    bit pu;
    bit po;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      sz = q.size();
      pu = iv && (sz < DEPTH);
      po = ordy && (sz > 0);
      if (iv && sz == DEPTH) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
    end
  endtask

  // Called at a falling edge; checks, drives, clocks, returns at next fall.
  task automatic step(input logic iv, input logic [7:0] d,
                      input logic ordy, input logic fl = 1'b0,
                      input logic clr = 1'b0);
    check_outputs();
    if (!fl && bus.out_valid && ordy) popped.push_back(bus.out_data);
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.out_ready  = ordy;
    flush          = fl;
    clear_overflow = clr;
    @(posedge clk);
    model_update(iv, d, ordy, fl, clr);
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    flush          = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_below", 32'(below_threshold), 32'h1);
    chk("rst_overflow", 32'(overflow), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // three bytes, then drain in order
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    step(1'b1, 8'h43, 1'b0);
    chk("abc_level", 32'(level), 32'd3);
    popped.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("abc_n", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("abc_0", 32'(popped[0]), 32'h41);
      chk("abc_1", 32'(popped[1]), 32'h42);
      chk("abc_2", 32'(popped[2]), 32'h43);
    end
    chk("abc_empty", 32'(empty), 32'h1);

    // fill to full, refused 17th push alongside a pop
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_in_ready", 32'(bus.in_ready), 32'h0);
    popped.delete();
    step(1'b1, 8'h10, 1'b1);
    chk("p17_level", 32'(level), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_n", 32'(popped.size()), 32'd16);
    if (popped.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("drain_seq", 32'(popped[i]), 32'(i));
    end
    for (int i = 0; i < 16; i++) step(1'b1, 8'h80 + 8'(i), 1'b0);
    chk("wrap_full", 32'(full), 32'h1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("wrap_empty", 32'(empty), 32'h1);

    // steady state at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h60 + 8'(i), 1'b1);
    chk("steady_level", 32'(level), 32'd5);
    step(1'b0, 8'h00, 1'b1);
    chk("thr_at4", 32'(below_threshold), 32'h0);
    step(1'b0, 8'h00, 1'b1);
    chk("thr_at3", 32'(below_threshold), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);

    // flush beats a concurrent push and pop
    for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_level", 32'(level), 32'h0);
    chk("flush_empty", 32'(empty), 32'h1);
    step(1'b0, 8'h00, 1'b1);

`ifdef VERMICOM_TX_FIFO_OVERFLOW_EN
    for (int i = 0; i < 16; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_head", 32'(bus.out_data), 32'hD0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'h0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_flush", 32'(overflow), 32'h0);
`endif

    // asynchronous reset mid-fill
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'h0);
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    q.delete();
    m_ovf = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 8'h99, 1'b0);
    chk("post_rst_level", 32'(level), 32'd1);

    // randomized traffic with varying push/pop bias
    for (int i = 0; i < 800; i++) begin
      int pv;
      int pr;
      pv = (i / 100) % 2 == 0 ? 80 : 30;
      pr = (i / 100) % 2 == 0 ? 30 : 80;
      step($urandom_range(99) < pv, 8'($urandom), $urandom_range(99) < pr,
           $urandom_range(63) == 0, $urandom_range(7) == 0);
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
